// File: rtl/lc3_mem_access.sv
// lc3_mem_access: data-memory access unit for the LC3 multicycle core.
// Services READ_MEM / READ_MEM_INDIR / WRITE_MEM requests from the controller
// against a req/ack data memory, holds the LDI/STI pointer between steps and
// pulses complete_data once per finished access.
// Optional feature: define LC3_MEMACC_TIMEOUT_EN to abort accesses whose ack
// does not arrive within TIMEOUT_CYCLES, flagging a sticky mem_err.
module lc3_mem_access #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  mem_state,
    input  logic [15:0] M_Addr,
    input  logic [15:0] M_Data,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [15:0] dmem_addr,
    output logic [15:0] dmem_wdata,
    input  logic [15:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        complete_data,
    output logic [15:0] memout,
    output logic        mem_err
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    localparam logic [1:0] OP_READ  = 2'd0;
    localparam logic [1:0] OP_INDIR = 2'd1;
    localparam logic [1:0] OP_WRITE = 2'd2;
    localparam logic [1:0] OP_NONE  = 2'd3;

    logic [1:0]  state;
    logic [1:0]  state_nxt;
    logic [15:0] ptr;
    logic        ptr_valid;
    logic [1:0]  last_op;
    logic        req_code_c;
    logic        start_c;
    logic        timeout_c;

    // A code is a request only in 0..2; it starts only if it differs from the last one serviced
    assign req_code_c = (mem_state < 3'd3);
    assign start_c    = (state == S_IDLE) && req_code_c && (mem_state[1:0] != last_op);

`ifdef LC3_MEMACC_TIMEOUT_EN
    logic [15:0] cnt;

    // Abort when this ack-less cycle brings the wait count up to the limit
    assign timeout_c = (state == S_ACCESS) && !dmem_ack &&
                       ((cnt + 16'd1) == 16'(TIMEOUT_CYCLES));

    // Ack wait counter, cleared on entry to ACCESS
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= 16'h0000;
        end else if (start_c) begin
            cnt <= 16'h0000;
        end else if (state == S_ACCESS && !dmem_ack) begin
            cnt <= cnt + 16'd1;
        end
    end
`else
    assign timeout_c = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (start_c) state_nxt = S_ACCESS;
            S_ACCESS: if (dmem_ack || timeout_c) state_nxt = S_DONE;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Registered memory interface, pointer, result and status
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dmem_req      <= 1'b0;
            dmem_we       <= 1'b0;
            dmem_addr     <= 16'h0000;
            dmem_wdata    <= 16'h0000;
            complete_data <= 1'b0;
            memout        <= 16'h0000;
            mem_err       <= 1'b0;
            ptr           <= 16'h0000;
            ptr_valid     <= 1'b0;
            last_op       <= OP_NONE;
        end else begin
            complete_data <= (state == S_ACCESS) && (dmem_ack || timeout_c);
            case (state)
                S_IDLE: begin
                    if (!req_code_c) begin
                        last_op <= OP_NONE;
                    end else if (start_c) begin
                        last_op  <= mem_state[1:0];
                        dmem_req <= 1'b1;
                        dmem_we  <= (mem_state[1:0] == OP_WRITE);
                        // Pointer fetch always uses M_Addr; the following step uses the pointer
                        if (mem_state[1:0] != OP_INDIR && ptr_valid) begin
                            dmem_addr <= ptr;
                        end else begin
                            dmem_addr <= M_Addr;
                        end
                        if (mem_state[1:0] == OP_WRITE) begin
                            dmem_wdata <= M_Data;
                        end
                    end
                end
                S_ACCESS: begin
                    if (dmem_ack) begin
                        dmem_req <= 1'b0;
                        case (last_op)
                            OP_INDIR: begin
                                ptr       <= dmem_rdata;
                                ptr_valid <= 1'b1;
                            end
                            OP_READ: begin
                                memout    <= dmem_rdata;
                                ptr_valid <= 1'b0;
                            end
                            default: ptr_valid <= 1'b0;
                        endcase
                    end else if (timeout_c) begin
                        dmem_req  <= 1'b0;
                        mem_err   <= 1'b1;
                        memout    <= 16'h0000;
                        ptr_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lc3_mem_access.sv
// Directed self-checking bench for lc3_mem_access.
module tb_lc3_mem_access;

    logic        clk;
    logic        rst;
    logic [2:0]  mem_state;
    logic [15:0] M_Addr;
    logic [15:0] M_Data;
    logic        dmem_req;
    logic        dmem_we;
    logic [15:0] dmem_addr;
    logic [15:0] dmem_wdata;
    logic [15:0] dmem_rdata;
    logic        dmem_ack;
    logic        complete_data;
    logic [15:0] memout;
    logic        mem_err;

    int errors = 0;
    int checks = 0;
    int n_complete = 0;

    lc3_mem_access #(.TIMEOUT_CYCLES(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .mem_state     (mem_state),
        .M_Addr        (M_Addr),
        .M_Data        (M_Data),
        .dmem_req      (dmem_req),
        .dmem_we       (dmem_we),
        .dmem_addr     (dmem_addr),
        .dmem_wdata    (dmem_wdata),
        .dmem_rdata    (dmem_rdata),
        .dmem_ack      (dmem_ack),
        .complete_data (complete_data),
        .memout        (memout),
        .mem_err       (mem_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count completion pulses seen at clock edges
    always @(posedge clk) if (complete_data) n_complete++;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One complete access: issue code, wait lat request cycles, ack with rd
    task automatic access(input string tag, input logic [2:0] code, input logic [15:0] addr,
                          input logic [15:0] data, input int lat, input logic [15:0] rd,
                          input logic [15:0] exp_addr, input logic exp_we);
        int c0;
        c0 = n_complete;
        mem_state = code;
        M_Addr    = addr;
        M_Data    = data;
        tick;
        check({tag, ".req"},  16'(dmem_req), 16'h1);
        check({tag, ".addr"}, dmem_addr, exp_addr);
        check({tag, ".we"},   16'(dmem_we), 16'(exp_we));
        if (exp_we) check({tag, ".wdata"}, dmem_wdata, data);
        repeat (lat) tick;
        if (lat > 0) begin
            check({tag, ".req_held"},  16'(dmem_req), 16'h1);
            check({tag, ".addr_held"}, dmem_addr, exp_addr);
        end
        dmem_ack   = 1'b1;
        dmem_rdata = rd;
        tick;
        dmem_ack   = 1'b0;
        dmem_rdata = 16'hDEAD;
        check({tag, ".req_drop"}, 16'(dmem_req), 16'h0);
        check({tag, ".cmpl"},     16'(complete_data), 16'h1);
        tick;
        check({tag, ".cmpl_off"}, 16'(complete_data), 16'h0);
        check({tag, ".npulse"},   16'(n_complete - c0), 16'h1);
    endtask

    initial begin
        int c0;
        int req_seen;
        int seen;
        rst        = 1'b1;
        mem_state  = 3'd3;
        M_Addr     = 16'h0000;
        M_Data     = 16'h0000;
        dmem_rdata = 16'h0000;
        dmem_ack   = 1'b0;
        tick;
        tick;
        rst = 1'b0;
        tick;

        // Reset state
        check("rst.req",   16'(dmem_req), 16'h0);
        check("rst.we",    16'(dmem_we), 16'h0);
        check("rst.addr",  dmem_addr, 16'h0000);
        check("rst.wdata", dmem_wdata, 16'h0000);
        check("rst.memout", memout, 16'h0000);
        check("rst.cmpl",  16'(complete_data), 16'h0);
        check("rst.err",   16'(mem_err), 16'h0);

        // LD
        access("ld", 3'd0, 16'h3000, 16'h0000, 3, 16'hBEEF, 16'h3000, 1'b0);
        check("ld.memout", memout, 16'hBEEF);

        // ST, ack in first request cycle
        access("st", 3'd2, 16'h3010, 16'h1234, 0, 16'hFFFF, 16'h3010, 1'b1);
        check("st.memout", memout, 16'hBEEF);

        // LDI: pointer fetch then read through pointer
        c0 = n_complete;
        access("ldi1", 3'd1, 16'h3020, 16'h0000, 1, 16'h4000, 16'h3020, 1'b0);
        check("ldi1.memout", memout, 16'hBEEF);
        access("ldi2", 3'd0, 16'h9999, 16'h0000, 2, 16'h00AA, 16'h4000, 1'b0);
        check("ldi.memout", memout, 16'h00AA);
        check("ldi.pulses", 16'(n_complete - c0), 16'h2);
        // Pointer consumed: next read uses M_Addr again
        mem_state = 3'd3;
        tick;
        access("ldi_after", 3'd0, 16'h1111, 16'h0000, 0, 16'h0055, 16'h1111, 1'b0);
        check("ldi_after.memout", memout, 16'h0055);

        // STI
        access("sti1", 3'd1, 16'h3030, 16'h0000, 0, 16'h5000, 16'h3030, 1'b0);
        access("sti2", 3'd2, 16'h3030, 16'h7777, 1, 16'h0000, 16'h5000, 1'b1);
        check("sti.memout", memout, 16'h0055);

        // Held code is not re-serviced
        mem_state = 3'd3;
        tick;
        access("hold", 3'd0, 16'h2000, 16'h0000, 1, 16'h1357, 16'h2000, 1'b0);
        req_seen = 0;
        c0 = n_complete;
        repeat (10) begin
            tick;
            if (dmem_req) req_seen++;
        end
        check("hold.no_req", 16'(req_seen), 16'h0);
        check("hold.no_cmpl", 16'(n_complete - c0), 16'h0);
        mem_state = 3'd3;
        tick;
        access("rehold", 3'd0, 16'h2002, 16'h0000, 0, 16'h2468, 16'h2002, 1'b0);
        check("rehold.memout", memout, 16'h2468);

        // mem_state changes during ACCESS are ignored
        mem_state = 3'd3;
        tick;
        mem_state = 3'd0;
        M_Addr    = 16'h2100;
        tick;
        check("chg.req", 16'(dmem_req), 16'h1);
        mem_state = 3'd1;
        M_Addr    = 16'h0BAD;
        tick;
        mem_state = 3'd3;
        tick;
        check("chg.addr", dmem_addr, 16'h2100);
        check("chg.we",   16'(dmem_we), 16'h0);
        dmem_ack   = 1'b1;
        dmem_rdata = 16'hC0DE;
        tick;
        dmem_ack = 1'b0;
        check("chg.cmpl",   16'(complete_data), 16'h1);
        check("chg.memout", memout, 16'hC0DE);
        tick;

        // Stray ack in IDLE is ignored
        c0 = n_complete;
        dmem_ack   = 1'b1;
        dmem_rdata = 16'h5A5A;
        tick;
        dmem_ack = 1'b0;
        tick;
        check("stray.req",    16'(dmem_req), 16'h0);
        check("stray.memout", memout, 16'hC0DE);
        check("stray.cmpl",   16'(n_complete - c0), 16'h0);

        // Asynchronous reset mid-access
        mem_state = 3'd0;
        M_Addr    = 16'h4444;
        tick;
        check("arst.req_on", 16'(dmem_req), 16'h1);
        #1;
        rst = 1'b1;
        #1;
        check("arst.req_off", 16'(dmem_req), 16'h0);
        mem_state = 3'd3;
        #1;
        rst = 1'b0;
        c0 = n_complete;
        dmem_ack   = 1'b1;
        dmem_rdata = 16'h7E7E;
        tick;
        dmem_ack = 1'b0;
        tick;
        check("arst.cmpl",   16'(n_complete - c0), 16'h0);
        check("arst.memout", memout, 16'h0000);
        check("arst.req",    16'(dmem_req), 16'h0);

`ifdef LC3_MEMACC_TIMEOUT_EN
        // No ack: access aborts with error after the wait limit
        mem_state = 3'd0;
        M_Addr    = 16'h6000;
        tick;
        mem_state = 3'd3;
        seen = 0;
        for (int i = 0; i < 12 && seen == 0; i++) begin
            tick;
            if (complete_data) seen = 1;
        end
        check("tmo.cmpl",   16'(seen), 16'h1);
        check("tmo.err",    16'(mem_err), 16'h1);
        check("tmo.memout", memout, 16'h0000);
        check("tmo.req",    16'(dmem_req), 16'h0);
`else
        // No timeout: request stays up indefinitely, mem_err stays low
        mem_state = 3'd0;
        M_Addr    = 16'h6000;
        tick;
        mem_state = 3'd3;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick;
            if (complete_data) seen = 1;
        end
        check("notmo.cmpl", 16'(seen), 16'h0);
        check("notmo.req",  16'(dmem_req), 16'h1);
        check("notmo.err",  16'(mem_err), 16'h0);
        dmem_ack   = 1'b1;
        dmem_rdata = 16'h0F0F;
        tick;
        dmem_ack = 1'b0;
        check("notmo.memout", memout, 16'h0F0F);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
